mel_frame_collector: RTL
========================

Name: mel_frame_collector

Overview:
- Stream-to-frame deserializer; the inverse of the frame-to-stream sample feeder.
- Accepts one W-bit sample per valid/ready handshake and packs N consecutive samples into a parallel frame. Presents the frame as an N-entry array with m_valid/m_ready.
- Double-buffered so the upstream stream (mel filter bank coefficient output, N=40) can keep flowing while the downstream consumer (log/DCT stage) holds the previous frame.

Parameters:
- N, 40, samples per frame (2..256).
- W, 16, sample width in bits.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  collector can accept a sample this cycle.
- s_data  in  W  sample value.
- s_last  in  1  marks the final sample of a frame; qualified by s_valid.
- m_valid  out  1  complete frame available on out.
- m_ready  in  1  downstream accepts the frame.
- out  out  W x N  unpacked array; out[0] is the first sample received.
- frame_err  out  1  one-cycle pulse on a frame length mismatch.

Behaviour:
- Storage and state:
  - Two banks of N x W registers (bank 0, bank 1).
  - wr_bank, rd_bank: 1 bit each.
  - wr_idx: clog2(N) bits.
  - full[1:0]: per-bank full flags.
- Reset (async, any time, including mid-frame or mid-hold):
  - wr_bank=0, rd_bank=0, wr_idx=0, full=00.
  - Both banks cleared to 0.
  - m_valid=0, frame_err=0, out=all zeros.
  - Any partially collected frame is discarded.
- s_ready = !full[wr_bank]. Purely registered-state derived; no combinational path from s_valid or m_ready.
- Accept = s_valid && s_ready:
  - bank[wr_bank][wr_idx] <= s_data.
  - Case wr_idx==N-1 (s_last ignored for storage): full[wr_bank]<=1, wr_bank toggles, wr_idx<=0. If s_last==0, frame_err pulses next cycle (missing last); the frame is still delivered.
  - Case wr_idx<N-1 and s_last==1 (short frame): frame dropped. wr_idx<=0, wr_bank unchanged, full unchanged, frame_err pulses next cycle. Stale bank entries are overwritten by the next frame.
  - Otherwise: wr_idx<=wr_idx+1.
- Output:
  - m_valid = full[rd_bank].
  - out = bank[rd_bank], directly from registers.
  - Stable while m_valid && !m_ready.
  - Transfer = m_valid && m_ready: full[rd_bank]<=0, rd_bank toggles.
- Latency: final sample accepted at edge t makes m_valid high after edge t, provided that bank is rd_bank (i.e. no older frame is pending).
- Throughput: with m_ready held high, s_ready never drops. One sample per cycle, no bubbles between frames.
- Simultaneous frame completion and frame transfer in the same cycle act on different banks and are both applied. The same bank cannot be written while full.
- Both banks full: s_ready=0 and the upstream stalls. s_ready rises the cycle after a transfer.
- frame_err is registered: high for exactly one cycle per mismatch event, never held.

Decomposition:
- Shared package audio_pkg:
  - localparam SAMPLE_W=16.
  - localparam MEL_BANDS=40.
  - typedef logic [SAMPLE_W-1:0] sample_t.
- Sub-module frame_bank:
  - One N x W register array.
  - Inputs: async clear, write enable, write index, write data.
  - Output: parallel array.
  - Instantiated twice; the top selects out by rd_bank.

Test Plan:
- Reset, then stream 40 samples 1..40 with s_last on the 40th, m_ready=1 -> m_valid one cycle after the last accept; out[0]=1, out[39]=40; frame_err never asserts.
- Three back-to-back frames (values k*100+i), s_valid and m_ready constantly 1 -> s_ready stays 1 for all 120 cycles; three m_valid pulses 40 cycles apart with correct contents.
- m_ready=0, stream 80 samples -> two frames buffered; s_ready=0 from the cycle after sample 80. Raise m_ready for one cycle -> frame 1 transferred, frame 2 now on out, s_ready=1 next cycle.
- s_last on the 10th sample -> frame_err one-cycle pulse, no m_valid. The next 40 samples (s_last on the 40th) produce a clean frame holding only the new values.
- 40 samples with s_last=0 throughout -> frame delivered, frame_err pulses once; sample 41 starts a new frame at index 0.
- Assert reset after sample 20 and while a full frame is held -> m_valid=0 and s_ready=1 immediately, out all zero; a following 40-sample frame is collected correctly.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio-pipeline definitions: default sample width, mel band count
// and the sample type used by the stages around the mel filter bank.
package audio_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int MEL_BANDS = 40;

  typedef logic [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/mel_frame_collector_frame_bank.sv
// One frame of storage: N registers of W bits. A single slot is written
// per cycle, and every slot is visible in parallel. An asynchronous clear
// returns all slots to zero.
module frame_bank
  import audio_pkg::*;
#(
  parameter int N  = MEL_BANDS,
  parameter int W  = SAMPLE_W,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [IW-1:0] i_idx,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_q [N]
);

  logic [W-1:0] r_q [N];

  // Slot storage: clear everything on reset, otherwise write the indexed slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        r_q[i] <= '0;
      end
    end else if (i_we) begin
      for (int i = 0; i < N; i++) begin
        if (i_idx == IW'(i)) begin
          r_q[i] <= i_data;
        end
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mel_frame_collector.sv
// Stream-to-frame deserializer. Collects N consecutive samples into one of
// two frame banks and presents a completed bank as a parallel frame. While
// the consumer holds one frame, the other bank keeps filling.
//
// Handshakes: a sample moves on a rising clk edge where s_valid && s_ready;
// a frame moves on an edge where m_valid && m_ready. s_ready and m_valid
// depend only on registered state, so neither has a combinational path from
// s_valid or m_ready. out holds steady while m_valid && !m_ready.
module mel_frame_collector
  import audio_pkg::*;
#(
  parameter int N = MEL_BANDS,
  parameter int W = SAMPLE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  input  logic         s_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] out [N],
  output logic         frame_err
);

  localparam int            IW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [IW-1:0] r_wr_idx;
  logic [1:0]    r_full;
  logic          r_frame_err;

  logic          w_accept;
  logic          w_last_slot;
  logic          w_xfer;
  logic          w_we0;
  logic          w_we1;
  logic [1:0]    w_full_nxt;
  logic [W-1:0]  w_bank0 [N];
  logic [W-1:0]  w_bank1 [N];

  assign s_ready     = !r_full[r_wr_bank];
  assign m_valid     = r_full[r_rd_bank];
  assign frame_err   = r_frame_err;

  assign w_accept    = s_valid && s_ready;
  assign w_last_slot = (r_wr_idx == LAST_IDX);
  assign w_xfer      = m_valid && m_ready;
  assign w_we0       = w_accept && !r_wr_bank;
  assign w_we1       = w_accept &&  r_wr_bank;

  frame_bank #(.N(N), .W(W), .IW(IW)) u_bank0 (
    .clk    (clk),
    .reset  (reset),
    .i_we   (w_we0),
    .i_idx  (r_wr_idx),
    .i_data (s_data),
    .o_q    (w_bank0)
  );

  frame_bank #(.N(N), .W(W), .IW(IW)) u_bank1 (
    .clk    (clk),
    .reset  (reset),
    .i_we   (w_we1),
    .i_idx  (r_wr_idx),
    .i_data (s_data),
    .o_q    (w_bank1)
  );

  // Full flags: completion sets the write bank, transfer clears the read
  // bank. Completion needs its bank empty and transfer needs its bank full,
  // so when both happen in one cycle they always touch different banks.
  always_comb begin
    w_full_nxt = r_full;
    if (w_accept && w_last_slot) begin
      w_full_nxt[r_wr_bank] = 1'b1;
    end
    if (w_xfer) begin
      w_full_nxt[r_rd_bank] = 1'b0;
    end
  end

  // Write-side control: slot index, bank switching and length checking.
  // A frame reaching N samples is always delivered, and a missing s_last is
  // only flagged. An early s_last drops the partial frame; its stale slots
  // are overwritten by the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_bank   <= 1'b0;
      r_wr_idx    <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (w_accept) begin
        if (w_last_slot) begin
          r_wr_bank   <= !r_wr_bank;
          r_wr_idx    <= '0;
          r_frame_err <= !s_last;
        end else if (s_last) begin
          r_wr_idx    <= '0;
          r_frame_err <= 1'b1;
        end else begin
          r_wr_idx    <= r_wr_idx + IW'(1);
        end
      end
    end
  end

  // Read side and shared full flags: advance to the other bank after each
  // transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_bank <= 1'b0;
      r_full    <= 2'b00;
    end else begin
      r_full <= w_full_nxt;
      if (w_xfer) begin
        r_rd_bank <= !r_rd_bank;
      end
    end
  end

  // Frame output: the read bank's registers, selected by r_rd_bank.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      out[i] = r_rd_bank ? w_bank1[i] : w_bank0[i];
    end
  end

endmodule
